// File: rtl/ram_arbiter_pkg.sv
// rtl/ram_arbiter_pkg.sv - configuration constants and shared types for ram_arbiter
//
// Package configure : build-time defaults (RAM_ARB_TIMEOUT feeds timeout_cycles).
// Package wires     : memory port records, arbiter state enum, arbiter register record.

package configure;

    // Default watchdog length in BUSY cycles (only used with RAM_ARB_TIMEOUT_EN).
    localparam int RAM_ARB_TIMEOUT = 1024;

endpackage

package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ram_arb_state_type;

    typedef struct packed {
        ram_arb_state_type state;
        logic              owner;   // port whose transaction is in flight
        logic              last;    // last granted port, breaks ties
        mem_in_type        ram_in;  // registered request to the RAM
    } ram_arb_reg_type;

    // last=1 so that port 0 wins the first tie after reset.
    localparam ram_arb_reg_type RAM_ARB_REG_RESET = '{
        state:  IDLE,
        owner:  1'b0,
        last:   1'b1,
        ram_in: '0
    };

endpackage

// File: rtl/ram_arb_buffer.sv
// rtl/ram_arb_buffer.sv - one-entry request buffer for one arbiter port
//
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   i_req        : requester request; captured whenever i_req.mem_valid=1
//   i_grant      : arbiter grants this port this cycle; clears o_pend
//   o_pend       : a captured request is waiting
//   o_req        : held request fields

module ram_arb_buffer
    import wires::*;
(
    input  logic       clock,
    input  logic       reset,
    input  mem_in_type i_req,
    input  logic       i_grant,
    output logic       o_pend,
    output mem_in_type o_req
);

    logic       r_pend;
    mem_in_type r_req;

    // A new valid wins over a grant on the same edge: the grant consumes the
    // old contents (already copied into ram_in) and the new request is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend <= 1'b0;
            r_req  <= '0;
        end else if (i_req.mem_valid) begin
            r_pend <= 1'b1;
            r_req  <= i_req;
        end else if (i_grant) begin
            r_pend <= 1'b0;
        end
    end

    assign o_pend = r_pend;
    assign o_req  = r_req;

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin arbiter sharing one RAM port between two requesters
//
// Optional feature macro: RAM_ARB_TIMEOUT_EN (BUSY watchdog of timeout_cycles).
//
// Ports:
//   clock, reset       : clock and synchronous active-high reset
//   req0_in / req0_out : requester 0 request / response
//   req1_in / req1_out : requester 1 request / response
//   ram_in             : registered request to the RAM (mem_valid for one cycle)
//   ram_out            : RAM response, routed combinationally to the owner

module ram_arbiter
    import wires::*;
#(
    parameter int timeout_cycles = configure::RAM_ARB_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  req0_in,
    output mem_out_type req0_out,
    input  mem_in_type  req1_in,
    output mem_out_type req1_out,
    output mem_in_type  ram_in,
    input  mem_out_type ram_out
);

    ram_arb_reg_type r_arb;
    ram_arb_reg_type w_arb;
    logic            w_pend0;
    logic            w_pend1;
    mem_in_type      w_buf0;
    mem_in_type      w_buf1;
    logic            w_grant0;
    logic            w_grant1;
    logic            w_busy;
    logic            w_done;
    logic            w_timeout;
    mem_out_type     w_rsp;

    ram_arb_buffer u_buf0 (
        .clock   (clock),
        .reset   (reset),
        .i_req   (req0_in),
        .i_grant (w_grant0),
        .o_pend  (w_pend0),
        .o_req   (w_buf0)
    );

    ram_arb_buffer u_buf1 (
        .clock   (clock),
        .reset   (reset),
        .i_req   (req1_in),
        .i_grant (w_grant1),
        .o_pend  (w_pend1),
        .o_req   (w_buf1)
    );

    assign w_busy = (r_arb.state == BUSY);
    // Ready seen in IDLE (e.g. after a reset mid-transaction) is ignored.
    assign w_done = w_busy && (ram_out.mem_ready || w_timeout);

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles) + 1;

    logic [CW-1:0] r_count;
    logic          r_timeout;

    // r_count equals the number of BUSY cycles since the issue cycle; the abort
    // response is registered so it appears the cycle after reaching the limit.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_count   <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_grant0 || w_grant1) begin
                r_count <= '0;
            end else if (w_busy && !ram_out.mem_ready) begin
                r_count <= r_count + 1'b1;
            end
            r_timeout <= w_busy && !ram_out.mem_ready && !r_timeout &&
                         (r_count == CW'(timeout_cycles - 1));
        end
    end

    assign w_timeout = r_timeout;
`else
    // No watchdog in this build: the abort condition can never hold.
    assign w_timeout = (timeout_cycles < 0);
`endif

    always_comb begin
        w_arb    = r_arb;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        if (w_busy) begin
            w_arb.ram_in.mem_valid = 1'b0;
        end
        if (w_done) begin
            w_arb.state = IDLE;
        end
        // Grant from IDLE or straight out of a completing transaction.
        if ((!w_busy || w_done) && (w_pend0 || w_pend1)) begin
            if (w_pend0 && (!w_pend1 || r_arb.last)) begin
                w_grant0 = 1'b1;
            end else begin
                w_grant1 = 1'b1;
            end
            w_arb.state            = BUSY;
            w_arb.owner            = w_grant1;
            w_arb.last             = w_grant1;
            w_arb.ram_in           = w_grant1 ? w_buf1 : w_buf0;
            w_arb.ram_in.mem_valid = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_arb <= RAM_ARB_REG_RESET;
        end else begin
            r_arb <= w_arb;
        end
    end

    always_comb begin
        req0_out = '0;
        req1_out = '0;
        w_rsp    = ram_out;
        if (w_timeout) begin
            w_rsp = '{mem_ready: 1'b1, mem_error: 1'b1, mem_rdata: 32'h0};
        end
        if (w_done) begin
            if (r_arb.owner) begin
                req1_out = w_rsp;
            end else begin
                req0_out = w_rsp;
            end
        end
    end

    assign ram_in = r_arb.ram_in;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - scoreboard bench for ram_arbiter

module tb_ram_arbiter;
    import wires::*;

    localparam int TO = 16;
`ifdef RAM_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    mem_in_type  req0_in = '0;
    mem_in_type  req1_in = '0;
    mem_out_type req0_out;
    mem_out_type req1_out;
    mem_in_type  ram_in;
    mem_out_type ram_out = '0;

    always #5 clock = ~clock;

    ram_arbiter #(.timeout_cycles(TO)) dut (
        .clock    (clock),
        .reset    (reset),
        .req0_in  (req0_in),
        .req0_out (req0_out),
        .req1_in  (req1_in),
        .req1_out (req1_out),
        .ram_in   (ram_in),
        .ram_out  (ram_out)
    );

    // tm: 0 no timing check, 1 issue two cycles after the send cycle,
    //     2 issue the cycle after the previous response
    typedef struct {
        int          port;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          lat;
        bit          hang;
        int          tm;
        int          cap;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   age = 0;
    int   rsp_cnt = 0;
    int   last_rsp_cyc = 0;
    bit   in_flight = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // RAM model: one-cycle ready lat cycles after the issue cycle.
    always @(posedge clock) begin
        #1;
        ram_out = '0;
        if (rsp_cnt > 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                ram_out.mem_ready = 1'b1;
                ram_out.mem_rdata = cur.rdata;
            end
        end
    end

    // Monitor: pops expected issues, checks routing of every response.
    always @(negedge clock) begin : mon
        exp_t        e;
        mem_out_type want;
        bit          to_hit;
        if (reset) begin
            in_flight = 0;
        end else begin
            if (in_flight) age++;
            if (ram_in.mem_valid) begin
                check("issue_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("issue_addr",  64'(ram_in.mem_addr),  64'(e.addr));
                    check("issue_wdata", 64'(ram_in.mem_wdata), 64'(e.wdata));
                    check("issue_wstrb", 64'(ram_in.mem_wstrb), 64'(e.wstrb));
                    check("issue_instr", 64'(ram_in.mem_instr), 64'(e.instr));
                    if (e.tm == 1) check("cap_to_issue", 64'(cyc), 64'(e.cap + 2));
                    if (e.tm == 2) check("rsp_to_issue", 64'(cyc), 64'(last_rsp_cyc + 1));
                    cur       = e;
                    in_flight = 1;
                    age       = 0;
                    rsp_cnt   = e.hang ? 0 : e.lat;
                end
            end
            to_hit = TO_EN && in_flight && cur.hang && (age == TO);
            if (in_flight && (ram_out.mem_ready || to_hit)) begin
                want.mem_ready = 1'b1;
                want.mem_error = to_hit;
                want.mem_rdata = to_hit ? 32'h0 : cur.rdata;
                check(cur.port == 0 ? "rsp_port0" : "rsp_port1",
                      64'(cur.port == 0 ? req0_out : req1_out), 64'(want));
                check("rsp_other_zero", 64'(cur.port == 0 ? req1_out : req0_out), 64'(0));
                in_flight    = 0;
                last_rsp_cyc = cyc;
            end else begin
                check("quiet0", 64'(req0_out), 64'(0));
                check("quiet1", 64'(req1_out), 64'(0));
            end
        end
    end

    task automatic tick();
        @(negedge clock);
        req0_in = '0;
        req1_in = '0;
    endtask

    task automatic send(input int port, input logic instr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input logic [31:0] rdata, input int lat, input bit hang,
                        input int tm, input bit push);
        mem_in_type r;
        exp_t       e;
        r.mem_valid = 1'b1;
        r.mem_instr = instr;
        r.mem_addr  = addr;
        r.mem_wdata = wdata;
        r.mem_wstrb = wstrb;
        if (port == 0) req0_in = r;
        else           req1_in = r;
        if (push) begin
            e = '{port, instr, addr, wdata, wstrb, rdata, lat, hang, tm, cyc};
            exp_q.push_back(e);
        end
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || in_flight) && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 64'(exp_q.size()) + 64'(in_flight), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        int sent;
        int got;
        int obs[8];

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ram_in",   64'(ram_in != '0), 64'(0));
        check("rst_req0_out", 64'(req0_out), 64'(0));
        check("rst_req1_out", 64'(req1_out), 64'(0));
        reset = 1'b0;
        tick();

        // Simultaneous after reset: port 0 first, port 1 right after its ready
        send(0, 1'b0, 32'h200, 32'h1234_5678, 4'hF, 32'h0,         2, 0, 1, 1);
        send(1, 1'b0, 32'h300, 32'h0,         4'h0, 32'hCAFE_0300, 2, 0, 2, 1);
        tick();
        drain(100);

        // Single read
        send(0, 1'b0, 32'h100, 32'h0, 4'h0, 32'hDEAD_BEEF, 3, 0, 1, 1);
        tick();
        drain(100);

        // Overwrite: port 1 0x10 replaced by 0x20; port 0 rebuffers while in flight
        send(0, 1'b0, 32'h40, 32'h0, 4'h0, 32'h0000_4040, 6, 0, 1, 1);
        tick();
        tick();
        send(1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0000_1010, 2, 0, 0, 0);
        tick();
        send(1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h0000_2020, 2, 0, 2, 1);
        tick();
        send(0, 1'b1, 32'h44, 32'h0, 4'h0, 32'h0000_4444, 1, 0, 2, 1);
        tick();
        drain(100);

        // Reset mid-BUSY; the RAM answers after reset and must be ignored
        send(0, 1'b0, 32'h500, 32'h55, 4'h3, 32'h5555_5555, 5, 0, 1, 1);
        n = 0;
        tick();
        while (!ram_in.mem_valid && n < 20) begin
            tick();
            n++;
        end
        check("rst_test_issue", 64'(ram_in.mem_valid), 64'(1));
        send(1, 1'b0, 32'h510, 32'h0, 4'h0, 32'h0, 1, 0, 0, 0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        check("midrst_ram_in", 64'(ram_in != '0), 64'(0));
        reset = 1'b0;
        tick();
        tick();
        check("stray_ready_req0", 64'(req0_out), 64'(0));
        check("stray_ready_req1", 64'(req1_out), 64'(0));
        repeat (4) tick();
        check("post_rst_ram_in", 64'(ram_in != '0), 64'(0));
        check("post_rst_q", 64'(exp_q.size()), 64'(0));

        // Saturation: each port reissues in its response cycle
        send(0, 1'b0, 32'h1000, 32'h0, 4'h0, 32'hB000_0000, 1, 0, 1, 1);
        send(1, 1'b1, 32'h2000, 32'h0, 4'h0, 32'hB000_0001, 2, 0, 2, 1);
        sent = 2;
        got  = 0;
        n    = 0;
        tick();
        while (got < 8 && n < 400) begin
            if (req0_out.mem_ready || req1_out.mem_ready) begin
                obs[got] = req1_out.mem_ready ? 1 : 0;
                got++;
                if (sent < 8) begin
                    send(obs[got-1], 1'b0, 32'(32'h1000 + sent * 16), 32'(32'hA000 + sent),
                         4'(sent), 32'(32'hB000_0000 + sent), 1 + sent % 3, 0, 2, 1);
                    sent++;
                end
            end
            tick();
            n++;
        end
        check("sat_count", 64'(got), 64'(8));
        for (int k = 0; k < 8; k++) begin
            check("sat_order", 64'(obs[k]), 64'(k % 2));
        end
        drain(100);

`ifdef RAM_ARB_TIMEOUT_EN
        // Watchdog: port 0 never answered, port 1 waits behind it
        send(0, 1'b0, 32'h600, 32'h0, 4'h0, 32'h0,         0, 1, 1, 1);
        tick();
        send(1, 1'b0, 32'h700, 32'h0, 4'h0, 32'h0000_7777, 2, 0, 2, 1);
        tick();
        drain(100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
